cues_ring_scheduler: RTL

- Synchronous sequencer for a self-timed C-element token ring.
- Loads per-stage EXBIN bypass masks and controls LOPEN.
- Injects a programmed number of tokens through a 4-phase SEND/ACK handshake at the ring head, then counts CP events from a monitor stage until a target count is reached.
- Sits between the host register block and the asynchronous ring. All asynchronous inputs are synchronised internally.

---
 rtl/cues_ring_scheduler.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/cues_ring_scheduler.sv
// Sequencer for a self-timed C-element token ring: loads EXBIN, injects tokens by 4-phase handshake, counts CP events.
// Optional CP period measurement is built when CUES_PERIOD_MEAS_EN is defined.
module cues_ring_scheduler #(
    parameter int NSTAGE = 8,
    parameter int SETTLE = 4,
    parameter int EVT_W  = 16,
    parameter int TO_W   = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              ABORT,
    input  logic [NSTAGE-1:0] CFG_EXB,
    input  logic [3:0]        CFG_TOKENS,
    input  logic [EVT_W-1:0]  CFG_EVENTS,
    input  logic [TO_W-1:0]   CFG_TIMEOUT,
    output logic [NSTAGE-1:0] EXBIN,
    output logic              LOPEN,
    output logic              SEND_INJ,
    input  logic              ACK_INJ,
    input  logic              CP_MON,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [1:0]        ERR_CODE,
    output logic [EVT_W-1:0]  EVT_CNT,
    output logic [TO_W-1:0]   PERIOD_MIN,
    output logic [TO_W-1:0]   PERIOD_MAX
);

    localparam int SET_W = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONFIG, S_INJ_REQ, S_INJ_REL, S_RUN, S_DRAIN, S_DONE, S_ERROR
    } state_e;

    localparam logic [1:0] CODE_TIMEOUT = 2'd1;
    localparam logic [1:0] CODE_BADCFG  = 2'd2;
    localparam logic [1:0] CODE_ABORT   = 2'd3;

    state_e            state_q, state_d;
    logic [NSTAGE-1:0] exbin_q, exbin_d;
    logic [3:0]        tokens_q, tokens_d;
    logic [EVT_W-1:0]  events_q, events_d;
    logic [TO_W-1:0]   timeout_q, timeout_d;
    logic [EVT_W-1:0]  evt_cnt_q, evt_cnt_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [TO_W-1:0]   wdog_q, wdog_d;
    logic              ack_s1_q, ack_s2_q;
    logic              cp_s1_q, cp_s2_q, cp_s3_q;

    logic cp_evt, busy, settle_done, cfg_bad, wdog_hit, wdog_state;

    // Third CP flop only remembers the previous synchronised level for edge detection.
    assign cp_evt      = cp_s2_q & ~cp_s3_q;
    assign busy        = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign settle_done = (settle_q == SET_W'(SETTLE - 1));
    assign cfg_bad     = ({28'd0, CFG_TOKENS} >= 32'(NSTAGE)) || (CFG_EXB == '0);
    assign wdog_state  = state_q inside {S_INJ_REQ, S_INJ_REL, S_RUN};
    assign wdog_hit    = wdog_state && (timeout_q != '0) && (wdog_q >= timeout_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        exbin_d    = exbin_q;
        tokens_d   = tokens_q;
        events_d   = events_q;
        timeout_d  = timeout_q;
        evt_cnt_d  = evt_cnt_q;
        err_code_d = err_code_q;
        settle_d   = settle_q + SET_W'(1);

        if (cp_evt && (state_q inside {S_RUN, S_DRAIN}) && (evt_cnt_q != '1))
            evt_cnt_d = evt_cnt_q + EVT_W'(1);

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (START) begin
                    tokens_d   = CFG_TOKENS;
                    events_d   = CFG_EVENTS;
                    timeout_d  = CFG_TIMEOUT;
                    evt_cnt_d  = '0;
                    err_code_d = 2'd0;
                    if (cfg_bad) begin
                        state_d    = S_ERROR;
                        err_code_d = CODE_BADCFG;
                        exbin_d    = '1;
                    end else begin
                        state_d = S_CONFIG;
                        exbin_d = CFG_EXB;
                    end
                end
            end
            S_CONFIG:  if (settle_done) state_d = (tokens_q != 4'd0) ? S_INJ_REQ : S_DRAIN;
            S_INJ_REQ: if (ack_s2_q) state_d = S_INJ_REL;
            S_INJ_REL: begin
                if (!ack_s2_q) begin
                    tokens_d = tokens_q - 4'd1;
                    state_d  = (tokens_q == 4'd1) ? S_RUN : S_INJ_REQ;
                end
            end
            S_RUN:     if (evt_cnt_d >= events_q) state_d = S_DRAIN;
            S_DRAIN:   if (settle_done) state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase

        // Abort outranks the watchdog and any same-cycle completion.
        if (busy && ABORT) begin
            state_d    = S_ERROR;
            err_code_d = CODE_ABORT;
            exbin_d    = '1;
        end else if (wdog_hit) begin
            state_d    = S_ERROR;
            err_code_d = CODE_TIMEOUT;
            exbin_d    = '1;
        end

        if (state_d != state_q) settle_d = '0;

        if ((state_d != state_q) || cp_evt) wdog_d = '0;
        else if (wdog_q != '1)              wdog_d = wdog_q + TO_W'(1);
        else                                wdog_d = wdog_q;
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            state_q    <= S_IDLE;
            exbin_q    <= '1;
            tokens_q   <= '0;
            events_q   <= '0;
            timeout_q  <= '0;
            evt_cnt_q  <= '0;
            err_code_q <= '0;
            settle_q   <= '0;
            wdog_q     <= '0;
            ack_s1_q   <= 1'b0;
            ack_s2_q   <= 1'b0;
            cp_s1_q    <= 1'b0;
            cp_s2_q    <= 1'b0;
            cp_s3_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            exbin_q    <= exbin_d;
            tokens_q   <= tokens_d;
            events_q   <= events_d;
            timeout_q  <= timeout_d;
            evt_cnt_q  <= evt_cnt_d;
            err_code_q <= err_code_d;
            settle_q   <= settle_d;
            wdog_q     <= wdog_d;
            ack_s1_q   <= ACK_INJ;
            ack_s2_q   <= ack_s1_q;
            cp_s1_q    <= CP_MON;
            cp_s2_q    <= cp_s1_q;
            cp_s3_q    <= cp_s2_q;
        end
    end

    assign EXBIN    = exbin_q;
    assign LOPEN    = (state_q != S_RUN);
    assign SEND_INJ = (state_q == S_INJ_REQ);
    assign BUSY     = busy;
    assign DONE     = (state_q == S_DONE);
    assign ERR      = (state_q == S_ERROR);
    assign ERR_CODE = err_code_q;
    assign EVT_CNT  = evt_cnt_q;

`ifdef CUES_PERIOD_MEAS_EN
    logic [TO_W-1:0] per_cnt_q, per_min_q, per_max_q;
    logic            per_seen_q;
    logic            start_acc;

    assign start_acc = START && !busy;

    // Period is the cycle distance between consecutive CP events seen in RUN.
    always_ff @(posedge CLK) begin
        if (RESET || start_acc) begin
            per_cnt_q  <= '0;
            per_min_q  <= '1;
            per_max_q  <= '0;
            per_seen_q <= 1'b0;
        end else if (state_q == S_RUN) begin
            if (cp_evt) begin
                if (per_seen_q) begin
                    if (per_cnt_q < per_min_q) per_min_q <= per_cnt_q;
                    if (per_cnt_q > per_max_q) per_max_q <= per_cnt_q;
                end
                per_seen_q <= 1'b1;
                per_cnt_q  <= TO_W'(1);
            end else if (per_cnt_q != '1) begin
                per_cnt_q <= per_cnt_q + TO_W'(1);
            end
        end
    end

    assign PERIOD_MIN = per_min_q;
    assign PERIOD_MAX = per_max_q;
`else
    assign PERIOD_MIN = '0;
    assign PERIOD_MAX = '0;
`endif

endmodule
